// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel counters, video window, line/frame strobes,
// frame counter and sync pulses delayed to line up with the renderer's colour register.
module vga_timing_gen #(
  parameter int h_video    = 640,
  parameter int h_front    = 16,
  parameter int h_sync     = 96,
  parameter int h_back     = 48,
  parameter int v_video    = 480,
  parameter int v_front    = 10,
  parameter int v_sync     = 2,
  parameter int v_back     = 33,
  parameter bit sync_pol   = 1'b0,
  parameter int sync_delay = 1
) (
  input  logic       clk_0,
  input  logic       rst,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = h_video + h_front + h_sync + h_back;
  localparam int V_TOTAL = v_video + v_front + v_sync + v_back;
  localparam int HS_BEG  = h_video + h_front;
  localparam int HS_END  = HS_BEG + h_sync;
  localparam int VS_BEG  = v_video + v_front;
  localparam int VS_END  = VS_BEG + v_sync;

  logic [9:0] h_q, h_d, v_q, v_d;
  logic [9:0] px_q, py_q;
  logic       vo_q, ls_q, fs_q, hs_q, vs_q, first_q;
  logic [7:0] fc_q, fc_d;
  logic       h_wrap, v_wrap, hs_act, vs_act;

  always_comb begin
    h_wrap = (h_q == 10'(H_TOTAL - 1));
    v_wrap = h_wrap && (v_q == 10'(V_TOTAL - 1));
    h_d    = h_wrap ? 10'd0 : h_q + 10'd1;
    v_d    = v_q;
    if (h_wrap) v_d = v_wrap ? 10'd0 : v_q + 10'd1;
    // The wrap out of the reset-held terminal count is not a completed frame.
    fc_d   = (v_wrap && !first_q) ? fc_q + 8'd1 : fc_q;
    // 11-bit compares so a boundary of exactly 1024 still works.
    hs_act = ({1'b0, h_d} >= 11'(HS_BEG)) && ({1'b0, h_d} < 11'(HS_END));
    vs_act = ({1'b0, v_d} >= 11'(VS_BEG)) && ({1'b0, v_d} < 11'(VS_END));
  end

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      h_q     <= 10'(H_TOTAL - 1);
      v_q     <= 10'(V_TOTAL - 1);
      px_q    <= '0;
      py_q    <= '0;
      vo_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fc_q    <= '0;
      first_q <= 1'b1;
      hs_q    <= ~sync_pol;
      vs_q    <= ~sync_pol;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      px_q    <= h_d;
      py_q    <= v_d;
      vo_q    <= ({1'b0, h_d} < 11'(h_video)) && ({1'b0, v_d} < 11'(v_video));
      ls_q    <= (h_d == 10'd0);
      fs_q    <= (h_d == 10'd0) && (v_d == 10'd0);
      fc_q    <= fc_d;
      first_q <= 1'b0;
      hs_q    <= hs_act ? sync_pol : ~sync_pol;
      vs_q    <= vs_act ? sync_pol : ~sync_pol;
    end
  end

  generate
    if (sync_delay > 0) begin : g_dly
      logic [sync_delay-1:0] hs_dly_q, vs_dly_q;
      always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
          hs_dly_q <= {sync_delay{~sync_pol}};
          vs_dly_q <= {sync_delay{~sync_pol}};
        end else begin
          hs_dly_q[0] <= hs_q;
          vs_dly_q[0] <= vs_q;
          for (int i = 1; i < sync_delay; i++) begin
            hs_dly_q[i] <= hs_dly_q[i-1];
            vs_dly_q[i] <= vs_dly_q[i-1];
          end
        end
      end
      assign hsync = hs_dly_q[sync_delay-1];
      assign vsync = vs_dly_q[sync_delay-1];
    end else begin : g_nodly
      assign hsync = hs_q;
      assign vsync = vs_q;
    end
  endgenerate

  assign pixel_x     = px_q;
  assign pixel_y     = py_q;
  assign video_on    = vo_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Four generator instances (default, inverted-polarity/no-delay, tiny and mid-size rasters)
// compared every cycle against an edge-count arithmetic model, with random async resets.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] px [4];
  logic [9:0] py [4];
  logic [7:0] fc [4];
  logic       vo [4], hs [4], vs [4], ls [4], fs [4];

  int n      = -1;
  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  vga_timing_gen u_def (
    .clk_0(clk), .rst(rst), .pixel_x(px[0]), .pixel_y(py[0]), .video_on(vo[0]),
    .hsync(hs[0]), .vsync(vs[0]), .line_start(ls[0]), .frame_start(fs[0]),
    .frame_count(fc[0]));

  vga_timing_gen #(.sync_pol(1'b1), .sync_delay(0)) u_p1 (
    .clk_0(clk), .rst(rst), .pixel_x(px[1]), .pixel_y(py[1]), .video_on(vo[1]),
    .hsync(hs[1]), .vsync(vs[1]), .line_start(ls[1]), .frame_start(fs[1]),
    .frame_count(fc[1]));

  vga_timing_gen #(.h_video(8), .h_front(2), .h_sync(2), .h_back(2),
                   .v_video(4), .v_front(1), .v_sync(1), .v_back(1)) u_sml (
    .clk_0(clk), .rst(rst), .pixel_x(px[2]), .pixel_y(py[2]), .video_on(vo[2]),
    .hsync(hs[2]), .vsync(vs[2]), .line_start(ls[2]), .frame_start(fs[2]),
    .frame_count(fc[2]));

  vga_timing_gen #(.h_video(64), .h_front(4), .h_sync(8), .h_back(4),
                   .v_video(48), .v_front(2), .v_sync(2), .v_back(3),
                   .sync_delay(2)) u_mid (
    .clk_0(clk), .rst(rst), .pixel_x(px[3]), .pixel_y(py[3]), .video_on(vo[3]),
    .hsync(hs[3]), .vsync(vs[3]), .line_start(ls[3]), .frame_start(fs[3]),
    .frame_count(fc[3]));

  // Number of rising edges since reset release, minus one; -1 while in reset.
  always @(posedge clk or negedge rst)
    if (!rst) n <= -1;
    else      n <= n + 1;

  // Expected outputs n edges after release, from the raster dimensions alone.
  function automatic logic [32:0] model(int e, int hv, int hf, int hsw, int hb,
                                        int vv, int vf, int vsw, int vb, bit pol, int dly);
    int ht, vt, x, y, f, m, xm, ym;
    bit hsa, vsa, vo_e, ls_e, fs_e, hs_e, vs_e;
    if (e < 0) return {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 8'd0, ~pol, ~pol};
    ht   = hv + hf + hsw + hb;
    vt   = vv + vf + vsw + vb;
    x    = e % ht;
    y    = (e / ht) % vt;
    f    = (e / (ht * vt)) % 256;
    vo_e = (x < hv) && (y < vv);
    ls_e = (x == 0);
    fs_e = (x == 0) && (y == 0);
    m    = e - dly;
    hsa  = 1'b0;
    vsa  = 1'b0;
    if (m >= 0) begin
      xm  = m % ht;
      ym  = (m / ht) % vt;
      hsa = (xm >= hv + hf) && (xm < hv + hf + hsw);
      vsa = (ym >= vv + vf) && (ym < vv + vf + vsw);
    end
    hs_e = hsa ? pol : ~pol;
    vs_e = vsa ? pol : ~pol;
    return {10'(x), 10'(y), vo_e, ls_e, fs_e, 8'(f), hs_e, vs_e};
  endfunction

  function automatic logic [32:0] pk(int i);
    return {px[i], py[i], vo[i], ls[i], fs[i], fc[i], hs[i], vs[i]};
  endfunction

  task automatic chk(string tag, logic [32:0] act, logic [32:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s n=%0d: got {x,y,vo,ls,fs,fc,hs,vs}=%h expected %h", tag, n, act, exp);
    end
  endtask

  task automatic check_all();
    chk("def", pk(0), model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1));
    chk("p1",  pk(1), model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 0));
    chk("sml", pk(2), model(n, 8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 1));
    chk("mid", pk(3), model(n, 64, 4, 8, 4, 48, 2, 2, 3, 1'b0, 2));
  endtask

  always @(negedge clk)
    if (chk_en) check_all();

  initial begin
    #2 rst = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    // Long enough for the tiny raster to pass 256 frames and wrap frame_count.
    for (int i = 0; i < 25400 && n_fail < 100; i++) @(posedge clk);
    for (int k = 0; k < 8 && n_fail < 100; k++) begin
      int run;
      run = $urandom_range(20, 2500);
      repeat (run) @(posedge clk);
      #($urandom_range(1, 3));
      rst = 1'b0;
      #1;
      check_all();
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #2 rst = 1'b1;
    end
    repeat (200) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
